// File: rtl/hack_pkg.sv
// hack_pkg: shared definitions for the Hack execution core.
// Instruction field positions, FSM state encoding, jump codes and the
// decoded control bundle handed from hack_ctrl_decode to hack_cpu.
package hack_pkg;

  localparam int INSTR_W = 16;
  localparam int DATA_W  = 16;

  // Instruction field bit positions
  localparam int BIT_CI    = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int BIT_A     = 12;  // y operand select: 1 = memory, 0 = A
  localparam int COMP_MSB  = 11;  // zx
  localparam int COMP_LSB  = 6;   // no
  localparam int BIT_D1    = 5;   // dest A
  localparam int BIT_D2    = 4;   // dest D
  localparam int BIT_D3    = 3;   // dest memory
  localparam int JUMP_MSB  = 2;
  localparam int JUMP_LSB  = 0;
  localparam int AVAL_MSB  = 14;  // A-instruction constant

  // Bit positions inside the 3-bit jump field
  localparam int J_LT = 2;
  localparam int J_EQ = 1;
  localparam int J_GT = 0;

  // Jump codes
  localparam logic [2:0] JMP_NULL = 3'b000;
  localparam logic [2:0] JMP      = 3'b111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RD_WAIT = 2'd1,
    HALT    = 2'd2
  } state_e;

  // Field order matches instr[11:6], so a straight cast fills it
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  typedef struct packed {
    logic       is_c;
    logic       a;
    alu_ctrl_t  alu;
    logic       d1;
    logic       d2;
    logic       d3;
    logic [2:0] jump;
  } ctrl_t;

endpackage

// File: rtl/hack_cpu_if.sv
// hack_cpu_if: data-memory port of the Hack core. The core is the master;
// the memory answers with read data and a ready that qualifies both strobes.
interface hack_cpu_if #(
  parameter int PC_W = 15
);
  logic [PC_W-1:0] mem_addr;
  logic [15:0]     mem_wdata;
  logic            mem_we;
  logic            mem_re;
  logic [15:0]     mem_rdata;
  logic            mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/alu.sv
// alu: Hack ALU. Optional zeroing/negation of each operand, add or AND,
// optional output negation; zr/ng flags describe the result.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x_z, x_n, y_z, y_n, res;

  assign x_z = zx ? 16'h0000 : x;
  assign x_n = nx ? ~x_z : x_z;
  assign y_z = zy ? 16'h0000 : y;
  assign y_n = ny ? ~y_z : y_z;
  assign res = f ? (x_n + y_n) : (x_n & y_n);
  assign out = no ? ~res : res;
  assign zr  = (out == 16'h0000);
  assign ng  = out[15];
endmodule

// File: rtl/hack_ctrl_decode.sv
// hack_ctrl_decode: combinational split of a Hack instruction into the
// control bundle. A-instructions yield an all-zero C-side bundle so no
// destination, memory access or jump can fire on them.
module hack_ctrl_decode
  import hack_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl
);
  // instr[14:13] carry no meaning in a C-instruction
  logic unused_bits;
  assign unused_bits = ^instr[14:13];

  // Field extraction for C-instructions, neutral bundle otherwise
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch.
    ctrl      = '0;
    ctrl.jump = JMP_NULL;
    if (instr[BIT_CI]) begin
      ctrl.is_c = 1'b1;
      ctrl.a    = instr[BIT_A];
      ctrl.alu  = alu_ctrl_t'(instr[COMP_MSB:COMP_LSB]);
      ctrl.d1   = instr[BIT_D1];
      ctrl.d2   = instr[BIT_D2];
      ctrl.d3   = instr[BIT_D3];
      ctrl.jump = instr[JUMP_MSB:JUMP_LSB];
    end
  end
endmodule

// File: rtl/hack_cpu.sv
// hack_cpu: Hack instruction execution core. Owns A, D and PC, drives the
// alu block, fetches from a combinational ROM and accesses data memory
// through a ready-gated handshake (hack_cpu_if).
// Optional feature macro: HACK_CPU_HALT_DETECT_EN -- stops the core on the
// "(END) @END; 0;JMP" idiom and raises halted.
module hack_cpu
  import hack_pkg::*;
#(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  hack_cpu_if.master         mem
);

  state_e            state_q;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  ctrl_t             ctrl;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zr, alu_ng;
  logic              jump_taken;
  logic              rd_issue;
  logic              retire;
  logic              halt_hit;

  hack_ctrl_decode u_decode (
    .instr (instr),
    .ctrl  (ctrl)
  );

  // In RD_WAIT the instruction is still the one at pc, so the same
  // decode selects the memory operand once the data is presented.
  assign alu_y = ctrl.a ? mem.mem_rdata : a_q;

  alu u_alu (
    .x   (d_q),
    .y   (alu_y),
    .zx  (ctrl.alu.zx),
    .nx  (ctrl.alu.nx),
    .zy  (ctrl.alu.zy),
    .ny  (ctrl.alu.ny),
    .f   (ctrl.alu.f),
    .no  (ctrl.alu.no),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign jump_taken = ctrl.is_c &&
                      ((ctrl.jump == JMP)                  ||
                       (ctrl.jump[J_LT] && alu_ng)         ||
                       (ctrl.jump[J_EQ] && alu_zr)         ||
                       (ctrl.jump[J_GT] && !alu_ng && !alu_zr));

  assign rd_issue = (state_q == RUN) && ctrl.is_c && ctrl.a;

  // A write-only instruction waits in RUN for ready; a read retires from
  // RD_WAIT on ready; everything else retires straight away.
  assign retire = ((state_q == RUN) && !ctrl.is_c)                                  ||
                  ((state_q == RUN) && ctrl.is_c && !ctrl.a &&
                   (!ctrl.d3 || mem.mem_ready))                                      ||
                  ((state_q == RD_WAIT) && mem.mem_ready);

`ifdef HACK_CPU_HALT_DETECT_EN
  // Unconditional jump back onto the preceding @label instruction
  assign halt_hit = ctrl.is_c && (ctrl.jump == JMP) &&
                    (a_q[PC_W-1:0] == (pc_q - PC_W'(1)));
  assign halted   = (state_q == HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // Architectural next values, applied only on a retiring edge
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q + PC_W'(1);
    if (!ctrl.is_c) begin
      a_d = DATA_W'(instr[AVAL_MSB:0]);
    end else begin
      if (ctrl.d1)   a_d  = alu_out;
      if (ctrl.d2)   d_d  = alu_out;
      if (jump_taken) pc_d = a_q[PC_W-1:0];
    end
  end

  // Memory port: address and write data come straight from A and the ALU,
  // so they hold by themselves while the core is stalled.
  assign mem.mem_addr  = a_q[PC_W-1:0];
  assign mem.mem_wdata = alu_out;
  assign mem.mem_re    = !rst && (rd_issue || (state_q == RD_WAIT));
  assign mem.mem_we    = !rst && ctrl.d3 &&
                         (((state_q == RUN) && !ctrl.a) || (state_q == RD_WAIT));

  assign pc = pc_q;

  // Control FSM plus A/D/PC registers, all updated together on retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, which is what makes the jump target use old A.
      if (retire) begin
        a_q  <= a_d;
        d_q  <= d_d;
        pc_q <= pc_d;
      end
      case (state_q)
        RUN: begin
          if (rd_issue)                  state_q <= RD_WAIT;
          else if (retire && halt_hit)   state_q <= HALT;
        end
        RD_WAIT: begin
          if (mem.mem_ready) state_q <= halt_hit ? HALT : RUN;
        end
        HALT:    state_q <= HALT;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: doc/hack_cpu.md
# hack_cpu

- Hack-instruction execution core and the control-side initiator of the existing `alu` block.
- Decodes each 16-bit instruction into the six ALU control bits plus destination and jump fields, and owns the A, D and PC registers.
- Talks to data memory through a ready-gated handshake and to instruction ROM through an asynchronous fetch port.

## Interface
Parameters:
- `PC_W`, 15, width of `pc` and `mem_addr`.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `instr`  in  16  instruction at `pc`; ROM is combinational, valid in the same cycle.
- `pc`  out  PC_W  address of the current instruction.
- `mem_rdata`  in  16  data-memory read data.
- `mem_ready`  in  1  memory accepts the write / presents the read data this cycle.
- `mem_addr`  out  PC_W  equals `A[PC_W-1:0]`.
- `mem_wdata`  out  16  ALU result.
- `mem_we`  out  1  write strobe.
- `mem_re`  out  1  read strobe.
- `halted`  out  1  core has stopped (see Configuration).

## Operation
- **A-instruction** (`instr[15]=0`): A <= zero-extended `instr[14:0]`.
- **C-instruction** (`instr[15]=1`; `instr[14:13]` ignored):
  - ALU operands: x = D; y = `instr[12]` ? `mem_rdata` : A.
  - ALU control: zx,nx,zy,ny,f,no = `instr[11:6]`.
  - Destinations: d1=`instr[5]` writes A, d2=`instr[4]` writes D, d3=`instr[3]` writes memory. Any combination is legal, including all three at once.
  - Jump: j1=`instr[2]` (out<0), j2=`instr[1]` (out==0), j3=`instr[0]` (out>0). Taken if any enabled condition holds; 111 is unconditional.
- Next PC: jump taken -> old A; otherwise pc+1, wrapping modulo 2^PC_W.
- Same-cycle A usage: memory address and jump target both use A before any same-cycle A update.
- Arithmetic is 16-bit two's complement; overflow wraps silently. ng = out[15]; zr = (out==0).
- FSM states: RUN, RD_WAIT, HALT.
  - RUN, memory read (a=1): assert `mem_re`, go to RD_WAIT; retire nothing.
  - RUN, memory write (d3=1 with a=0): assert `mem_we`. If `mem_ready`=1, retire; otherwise stay in RUN with all state frozen.
  - RUN, all other instructions: retire in 1 cycle.
  - RD_WAIT: hold `mem_re` and `mem_addr`. On the cycle with `mem_ready`=1, compute using `mem_rdata`, retire, return to RUN. If d3 is also set, `mem_we` is asserted in this same cycle with `mem_ready` acting for both the read and the write.
  - HALT: all strobes 0; no state changes. Left only by reset.
- Retire means: A, D and PC update together on one clock edge.

## Timing
- Reset values: pc=RESET_PC, A=0, D=0, state=RUN, `halted`=0.
- `mem_we` and `mem_re` are forced to 0 while `rst`=1.
- Latency:
  - non-memory instruction: 1 cycle.
  - write: 1 cycle + cycles with `mem_ready` low.
  - read: 2 cycles minimum, +1 per extra cycle `mem_ready` is low in RD_WAIT.
- While stalled: `mem_addr`, `mem_wdata` and the strobes are held stable; `pc` is unchanged.
- `mem_ready` is ignored unless a strobe is asserted.
- Reset asserted mid-stall or in HALT: immediate return to reset values; the pending access is abandoned with no write committed.
- PC wrap: pc=2^PC_W-1, no jump -> pc=0.

## Configuration
- Macro `HACK_CPU_HALT_DETECT_EN`.
- **Defined:** an unconditional jump (jjj=111) whose old A equals pc-1 (the `(END) @END; 0;JMP` idiom) retires normally with pc <= A, then enters HALT. `halted`=1 from the following cycle.
- **Undefined:** no HALT state; `halted` tied to 0; such loops execute forever.

## Structure
- Package `hack_pkg` holds:
  - instruction field bit positions;
  - the state enum (RUN, RD_WAIT, HALT);
  - the jump-code constants;
  - a `ctrl_t` struct (alu bits, a, dest, jump).
- Sub-module `hack_ctrl_decode`: purely combinational `instr` -> `ctrl_t`.
- The existing `alu` block is instantiated unchanged for compute, zr and ng.

## Test plan
- Reset with `rst` pulsed mid-run: pc=0, A=0, D=0, strobes 0 during reset.
- `0x0005` then `0xEC10` (D=A): D=5, pc=2 after 2 cycles.
- `@100` then `0xE308` (M=D, D=5) with `mem_ready` low for 3 cycles:
  - `mem_we`=1, `mem_addr`=100, `mem_wdata`=5 held for 4 cycles;
  - pc advances only on the ready cycle.
- `0xFC10` (D=M) with `mem_rdata`=0x1234, `mem_ready` high on the 2nd RD_WAIT cycle: D=0x1234, instruction takes 3 cycles.
- `@10`, `0xEE90` (D=-1), `0xE304` (D;JLT): pc=10. Repeated with D=5: not taken, pc advances by 1.
- `@6` at pc 6, `0xEA87` at pc 7:
  - with the macro: pc=6, `halted`=1, then frozen;
  - without it: pc alternates 6/7 and `halted` stays 0.
